// File: rtl/board_scan_reader.sv
// Reader side of the 144-bit board bus: once per frame period the board is
// snapshotted and every cell is streamed in raster order over valid/ready.
module board_scan_reader #(
  parameter int FRAME_DIV = 833333,
  parameter int COLS      = 8,
  parameter int ROWS      = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [143:0] data_updated,
  output logic         cell_valid,
  input  logic         cell_ready,
  output logic [2:0]   cell_x,
  output logic [4:0]   cell_y,
  output logic         cell_on,
  output logic         draw_finish,
  output logic         frame_overrun
);

  localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [2:0]       X_LAST   = 3'(COLS - 1);
  localparam logic [4:0]       Y_LAST   = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_count;
  logic             tick;
  logic [143:0]     snapshot;
  logic [7:0]       cell_index;
  logic             beat_accept;
  logic             last_cell;

  // Free-running frame divider; it never pauses, so frame timing is independent of the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_count <= '0;
    end else if (div_count == DIV_LAST) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + DIV_ONE;
    end
  end

  assign tick        = (div_count == DIV_LAST);
  assign cell_index  = {cell_y, 3'b000} + {5'b00000, cell_x};
  assign beat_accept = cell_valid && cell_ready;
  assign last_cell   = (cell_x == X_LAST) && (cell_y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = LATCH;
      LATCH:   state_next = SCAN;
      SCAN:    if (beat_accept && last_cell) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cell_valid    = 1'b0;
    draw_finish   = 1'b0;
    cell_on       = 1'b0;
    frame_overrun = tick && (state != IDLE);
    case (state)
      SCAN: begin
        cell_valid = 1'b1;
        cell_on    = snapshot[cell_index];
      end
      DONE:    draw_finish = 1'b1;
      default: ;
    endcase
  end

  // The position wraps back to (0,0) after the final cell so cell_y never reaches ROWS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      cell_x   <= '0;
      cell_y   <= '0;
    end else if (state == LATCH) begin
      snapshot <= data_updated;
      cell_x   <= '0;
      cell_y   <= '0;
    end else if (beat_accept) begin
      if (last_cell) begin
        cell_x <= '0;
        cell_y <= '0;
      end else if (cell_x == X_LAST) begin
        cell_x <= '0;
        cell_y <= cell_y + 5'd1;
      end else begin
        cell_x <= cell_x + 3'd1;
      end
    end
  end

endmodule

// File: doc/board_scan_reader.md
Name: board_scan_reader

Overview:
- Reader side of the 144-bit board bus; `data_updated` is 8 columns x 18 rows, index = x + 8*y.
- Once per frame period, snapshots the board and streams every cell in raster order to the display writer over a valid/ready handshake.
- Pulses `draw_finish` for exactly one cycle when the frame's last cell has been accepted. The game controller updates the board only on that pulse.
- Frame timing is generated internally from a clock-cycle divider.

Parameters:
- FRAME_DIV, 833333, clock cycles per frame period (60 Hz at 50 MHz); legal range >= 2.
- COLS, 8, board width in cells; fixed so that COLS*ROWS = 144.
- ROWS, 18, board height in cells.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_updated  in  144  board contents from the game controller; bit x+8*y set means cell (x,y) is occupied.
- cell_valid  out  1  cell beat presented.
- cell_ready  in  1  display writer accepts the beat.
- cell_x  out  3  column of the current beat, 0..7.
- cell_y  out  5  row of the current beat, 0..17.
- cell_on  out  1  occupancy of the current cell, taken from the snapshot.
- draw_finish  out  1  one-cycle pulse after the frame's final cell is accepted.
- frame_overrun  out  1  one-cycle pulse when a frame tick arrives while a scan is still in progress.

Behaviour:

Reset:
- `rst_n` low, asynchronously: FSM goes to IDLE.
- Divider, cell_x, cell_y, snapshot, cell_valid, cell_on, draw_finish and frame_overrun all go to 0.
- Reset mid-scan abandons the frame. No draw_finish is produced for it.

Divider:
- Counts 0..FRAME_DIV-1 and wraps.
- `tick` is asserted in the cycle the count equals FRAME_DIV-1.
- Free-running in every state. After reset release, the first tick occurs at cycle FRAME_DIV-1.

FSM states:
- IDLE: cell_valid=0. On tick -> LATCH.
- LATCH (1 cycle):
  - snapshot <= data_updated.
  - cell_x <= 0, cell_y <= 0.
  - -> SCAN.
- SCAN:
  - cell_valid=1; cell_on = snapshot[cell_x + 8*cell_y]. cell_on is valid only while cell_valid=1 and is 0 otherwise.
  - cell_x, cell_y and cell_on are held stable while cell_valid=1 and cell_ready=0.
  - On cell_valid && cell_ready:
    - if cell_x < 7: cell_x++.
    - else: cell_x <= 0 and cell_y++.
    - if (7,17) is accepted: -> DONE.
- DONE (1 cycle):
  - cell_valid=0, draw_finish=1.
  - -> IDLE.

Latency and throughput:
- Tick to first cell_valid: 2 cycles.
- With cell_ready held high: 144 consecutive beats, then draw_finish one cycle after the (7,17) beat.
- Minimum frame = 1 + 144 + 1 = 146 cycles. A period of FRAME_DIV >= 147 guarantees no overrun under full throughput.

Snapshot rules:
- Changes to data_updated after LATCH do not affect the current frame.
- data_updated is sampled only in LATCH.

Overrun:
- A tick in LATCH, SCAN or DONE is dropped; frame_overrun pulses for 1 cycle.
- The scan continues unaffected. The next scan starts on the next tick seen in IDLE.

Simultaneous events:
- A tick in the same cycle as the final accept counts as an overrun (the FSM is in SCAN).
- A tick in the IDLE cycle immediately after DONE starts a new frame normally.

Width rules:
- Cell index is computed as {cell_y, 3'b000} + cell_x, 8 bits wide, range 0..143.
- cell_y never exceeds 17; cell_x wraps 7 -> 0.

Test Plan:
- FRAME_DIV=200, cell_ready=1, data_updated bit 58 set (x=2, y=7):
  - first cell_valid at cycle 201.
  - exactly 144 beats; cell_on=1 only on beat (2,7).
  - draw_finish a single pulse one cycle after the (7,17) beat.
  - frame_overrun never asserted.
- Backpressure: cell_ready toggles 1,0,0,1 repeating -> cell_x, cell_y, cell_on stable during stalls; beat order exactly raster 0..143; draw_finish occurs once.
- Snapshot isolation: all-ones board latched, then data_updated forced to 0 during SCAN -> all 144 beats have cell_on=1; the following frame has all 144 beats with cell_on=0.
- Overrun: FRAME_DIV=100 with cell_ready=1 -> frame_overrun pulses; frames complete every second period; no beat is skipped or repeated.
- Reset mid-scan: rst_n low at beat 50 for 3 cycles -> all outputs 0 immediately (asynchronous); no draw_finish; next scan starts at (0,0) FRAME_DIV-1 cycles after release.
- Corner cells: board with only bits 0 and 143 set -> cell_on=1 only at (0,0) and (7,17); cell_y peaks at 17 and never reaches 18.
